// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the two-requester serial adder: default operand
// width, FSM state encoding and the round-robin pick used by the arbiter.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  // A lone requester wins outright; on a tie the requester not served last wins.
  function automatic logic rr_pick(input logic i_req0, input logic i_req1, input logic i_last);
    if (i_req0 && i_req1) begin
      return ~i_last;
    end
    return i_req1;
  endfunction

endpackage

// File: rtl/serial_add_arbiter_if.sv
// Requester-side bus of the serial adder arbiter.
//
// Handshake: REQx is the requester's valid. Once raised it stays high, with
// Ax/Bx stable, until the block answers with a one-cycle GNTx pulse (the
// ready/accept), which means the operands were captured on the edge that
// raised GNTx. DONEx is a one-cycle pulse qualifying SUM/COUT for requester x;
// SUM/COUT then hold until the next DONE. BUSY is high whenever the block is
// not idle.
interface serial_add_arbiter_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             REQ0;
  logic             REQ1;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             GNT0;
  logic             GNT1;
  logic             DONE0;
  logic             DONE1;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             BUSY;

  modport master (
    output REQ0, REQ1, A0, B0, A1, B1,
    input  GNT0, GNT1, DONE0, DONE1, SUM, COUT, BUSY
  );

  modport slave (
    input  REQ0, REQ1, A0, B0, A1, B1,
    output GNT0, GNT1, DONE0, DONE1, SUM, COUT, BUSY
  );

endinterface

// File: rtl/serial_add_arbiter_datapath.sv
// Bit-serial adder datapath: operand shift registers, carry flip-flop and a
// sum shift register filled from the MSB. o_sum/o_cout present the result as
// it will look after the current shift, so the controller can latch the final
// value on the same edge as the last shift.
module serial_add_datapath
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum_shifted;

  assign w_bit         = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_sum_shifted = WIDTH'({w_bit, r_sum_sr} >> 1);

  assign o_sum  = w_sum_shifted;
  assign o_cout = w_carry;

  // Load captures fresh operands and clears carry; shift consumes one LSB per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
    end else if (i_load) begin
      r_a      <= i_a;
      r_b      <= i_b;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
    end else if (i_shift) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_sum_sr <= w_sum_shifted;
      r_carry  <= w_carry;
    end
  end

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester front end sharing one bit-serial adder. A round-robin
// arbiter picks a requester in IDLE, the datapath runs WIDTH WORK cycles,
// and a single DONE cycle publishes SUM/COUT before returning to IDLE.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  serial_add_arbiter_if.slave  bus,
  output state_t               o_dbg_state
);

  localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             w_gnt0_nxt;
  logic             w_gnt1_nxt;
  logic             w_done0_nxt;
  logic             w_done1_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             r_cout;
  logic             w_cout_nxt;

  logic             w_winner;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_dp_sum;
  logic             w_dp_cout;

  assign w_winner = rr_pick(bus.REQ0, bus.REQ1, r_last);
  assign w_op_a   = w_winner ? bus.A1 : bus.A0;
  assign w_op_b   = w_winner ? bus.B1 : bus.B0;

  serial_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_sum   (w_dp_sum),
    .o_cout  (w_dp_cout)
  );

  // Next-state and next-output decode; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          w_load      = 1'b1;
          w_count_nxt = '0;
          w_owner_nxt = w_winner;
          w_gnt0_nxt  = ~w_winner;
          w_gnt1_nxt  = w_winner;
          w_state_nxt = WORK;
        end
      end
      WORK: begin
        w_shift = 1'b1;
        if (r_count == LAST_COUNT) begin
          w_count_nxt = '0;
          w_sum_nxt   = w_dp_sum;
          w_cout_nxt  = w_dp_cout;
          w_last_nxt  = r_owner;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_count <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
    end
  end

  assign bus.GNT0  = r_gnt0;
  assign bus.GNT1  = r_gnt1;
  assign bus.DONE0 = r_done0;
  assign bus.DONE1 = r_done1;
  assign bus.SUM   = r_sum;
  assign bus.COUT  = r_cout;
  assign bus.BUSY  = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: table of single-requester operations,
// hand-written multi-cycle sequences, and a randomized two-requester run
// checked by a transaction-level scoreboard.
module tb_serial_add_arbiter;
  import serial_add_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic   CLK = 1'b0;
  logic   RST;
  state_t dbg_state;
  int     cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();

  serial_add_arbiter #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic           mon_on = 1'b0;
  logic [W+1:0]   exp_q[$];      // {owner, cout, sum}
  int             gcyc_q[$];
  logic           m_last;
  logic           p_req0, p_req1;
  logic [W-1:0]   p_a0, p_b0, p_a1, p_b1;

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[8];
  int   g_ids[$];
  int   d_cyc[$];
  int   gc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input int id, input logic req, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      bus.REQ0 = req; bus.A0 = a; bus.B0 = b;
    end else begin
      bus.REQ1 = req; bus.A1 = a; bus.B1 = b;
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) bus.REQ0 = 1'b0;
    else         bus.REQ1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.BUSY !== 1'b0 && k < 30) begin
      tick();
      k++;
    end
    check(name, bus.BUSY, 0);
  endtask

  // Single uncontended operation with exact cycle timing from grant to done.
  task automatic do_op(input string name, input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic ec);
    drive(id, 1'b1, a, b);
    tick();
    check({name, "_gnt"}, (id == 0) ? bus.GNT0 : bus.GNT1, 1);
    check({name, "_busy"}, bus.BUSY, 1);
    drop(id);
    for (int k = 1; k <= W; k++) begin
      tick();
      check({name, "_done"}, (id == 0) ? bus.DONE0 : bus.DONE1, (k == W));
    end
    check({name, "_sum"}, bus.SUM, es);
    check({name, "_cout"}, bus.COUT, ec);
    tick();
    check({name, "_idle"}, bus.BUSY, 0);
  endtask

  // Random requester: random idle gap, random operands, holds until granted.
  task automatic rand_req(input int id, input int nops);
    for (int n = 0; n < nops; n++) begin
      int   gap;
      logic got;
      gap = $urandom_range(0, 6);
      repeat (gap) tick();
      drive(id, 1'b1, W'($urandom), W'($urandom));
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        tick();
        if (((id == 0) ? bus.GNT0 : bus.GNT1) === 1'b1) got = 1'b1;
      end
      check((id == 0) ? "rand_gnt0_wait" : "rand_gnt1_wait", got, 1);
      if ($urandom_range(0, 1) == 1) drive(id, 1'b0, W'($urandom), W'($urandom));
      else drop(id);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int   busy_low;
    logic seen_done;

    RST = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);

    // Scoreboard monitor: predicts winner and result from the sampled inputs.
    fork
      forever begin
        @(negedge CLK);
        if (!RST) begin
          exp_q.delete();
          gcyc_q.delete();
          m_last = 1'b1;
        end else if (mon_on) begin
          check("gnt_excl", bus.GNT0 & bus.GNT1, 0);
          check("done_excl", bus.DONE0 & bus.DONE1, 0);
          check("gnt_done_excl", (bus.GNT0 | bus.GNT1) & (bus.DONE0 | bus.DONE1), 0);
          if (bus.GNT0 | bus.GNT1) begin
            logic      w;
            logic [W:0] full;
            check("gnt_had_req", p_req0 | p_req1, 1);
            w = (p_req0 && p_req1) ? ~m_last : p_req1;
            check("gnt_owner", bus.GNT1, w);
            full = w ? ({1'b0, p_a1} + {1'b0, p_b1}) : ({1'b0, p_a0} + {1'b0, p_b0});
            exp_q.push_back({w, full});
            gcyc_q.push_back(cyc);
          end
          if (bus.DONE0 | bus.DONE1) begin
            if (exp_q.size() == 0) begin
              check("done_unexpected", 1, 0);
            end else begin
              logic [W+1:0] e;
              int           g;
              e = exp_q.pop_front();
              g = gcyc_q.pop_front();
              check("done_owner", bus.DONE1, e[W+1]);
              check("sb_result", {bus.COUT, bus.SUM}, e[W:0]);
              check("sb_latency", cyc - g, W);
              m_last = e[W+1];
            end
          end
        end
        p_req0 = bus.REQ0; p_req1 = bus.REQ1;
        p_a0 = bus.A0; p_b0 = bus.B0; p_a1 = bus.A1; p_b1 = bus.B1;
      end
    join_none

    // Reset state
    #3 RST = 1'b0;
    repeat (3) tick();
    check("rst_gnt0", bus.GNT0, 0);
    check("rst_gnt1", bus.GNT1, 0);
    check("rst_done0", bus.DONE0, 0);
    check("rst_done1", bus.DONE1, 0);
    check("rst_sum", bus.SUM, 0);
    check("rst_cout", bus.COUT, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_state", dbg_state, IDLE);
    RST = 1'b1;
    mon_on = 1'b1;

    // Table of uncontended operations (first one follows reset release directly)
    tbl[0] = '{0, 8'h5A, 8'h3C, 8'h96, 1'b0};
    tbl[1] = '{1, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{0, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[3] = '{1, 8'h12, 8'h34, 8'h46, 1'b0};
    tbl[4] = '{0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[5] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{0, 8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[7] = '{1, 8'hAA, 8'h55, 8'hFF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout);
    end

    // Simultaneous requests after reset: requester 0 wins the first tie
    RST = 1'b0;
    tick();
    RST = 1'b1;
    drive(0, 1'b1, 8'hFF, 8'h01);
    drive(1, 1'b1, 8'h12, 8'h34);
    tick();
    check("tie_gnt0", bus.GNT0, 1);
    check("tie_gnt1", bus.GNT1, 0);
    drop(0);
    repeat (W) tick();
    check("tie_done0", bus.DONE0, 1);
    check("tie_sum0", bus.SUM, 8'h00);
    check("tie_cout0", bus.COUT, 1);
    tick();
    check("tie_gap_gnt1", bus.GNT1, 0);
    check("tie_gap_busy", bus.BUSY, 0);
    tick();
    check("tie_gnt1_late", bus.GNT1, 1);
    drop(1);
    repeat (W) tick();
    check("tie_done1", bus.DONE1, 1);
    check("tie_sum1", bus.SUM, 8'h46);
    check("tie_cout1", bus.COUT, 0);
    tick();

    // Both held for four operations: alternating grants, DONE every W+2 cycles
    drive(0, 1'b1, W'($urandom), W'($urandom));
    drive(1, 1'b1, W'($urandom), W'($urandom));
    g_ids.delete();
    d_cyc.delete();
    for (int k = 0; k < 80 && d_cyc.size() < 4; k++) begin
      tick();
      if (bus.GNT0 === 1'b1) g_ids.push_back(0);
      if (bus.GNT1 === 1'b1) g_ids.push_back(1);
      if ((bus.DONE0 | bus.DONE1) === 1'b1) begin
        d_cyc.push_back(cyc);
        if (d_cyc.size() == 4) begin
          drop(0);
          drop(1);
        end
      end
    end
    check("rr_done_count", d_cyc.size(), 4);
    check("rr_grant_count", g_ids.size(), 4);
    for (int i = 0; i < g_ids.size() && i < 4; i++) check($sformatf("rr_order%0d", i), g_ids[i], i % 2);
    for (int i = 1; i < d_cyc.size(); i++) check($sformatf("rr_spacing%0d", i), d_cyc[i] - d_cyc[i-1], W + 2);
    wait_idle("rr_idle");

    // Reset in the 4th WORK cycle discards the operation
    drive(0, 1'b1, W'($urandom), W'($urandom));
    tick();
    check("abort_gnt0", bus.GNT0, 1);
    drop(0);
    repeat (3) tick();
    check("abort_busy_before", bus.BUSY, 1);
    RST = 1'b0;
    #1;
    check("abort_gnt0_rst", bus.GNT0, 0);
    check("abort_done0_rst", bus.DONE0, 0);
    check("abort_sum_rst", bus.SUM, 0);
    check("abort_cout_rst", bus.COUT, 0);
    check("abort_busy_rst", bus.BUSY, 0);
    check("abort_state_rst", dbg_state, IDLE);
    tick();
    RST = 1'b1;
    seen_done = 1'b0;
    repeat (W + 2) begin
      tick();
      if ((bus.DONE0 | bus.DONE1) === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    do_op("post_abort", 1, 8'h80, 8'h80, 8'h00, 1'b1);

    // Operand change after capture has no effect
    drive(0, 1'b1, 8'h01, 8'h01);
    tick();
    check("hold_gnt0", bus.GNT0, 1);
    drive(0, 1'b0, 8'hFF, 8'h01);
    repeat (W) tick();
    check("hold_done0", bus.DONE0, 1);
    check("hold_sum", bus.SUM, 8'h02);
    check("hold_cout", bus.COUT, 0);
    tick();

    // REQ0 held continuously: grants W+2 apart, one idle cycle between
    drive(0, 1'b1, W'($urandom), W'($urandom));
    gc.delete();
    busy_low = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.GNT0 === 1'b1) gc.push_back(cyc);
      if (gc.size() >= 1 && gc.size() < 3 && bus.BUSY === 1'b0) busy_low++;
    end
    drop(0);
    check("cont_grants", gc.size(), 3);
    for (int i = 1; i < gc.size(); i++) check($sformatf("cont_gap%0d", i), gc[i] - gc[i-1], W + 2);
    check("cont_busy_low", busy_low, 2);
    wait_idle("cont_idle");

    // Randomized contention checked by the scoreboard
    fork
      rand_req(0, 20);
      rand_req(1, 20);
    join
    wait_idle("rand_idle");
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
